// File: rtl/xgemac_pkg.sv
`default_nettype none
// ============================================================================
// xgemac_pkg: shared rx word type, drain FSM states and length helper. Rev 1.0
// ============================================================================
package xgemac_pkg;

    localparam int XGE_DATA_W = 64;
    localparam int XGE_MOD_W  = 3;
    localparam int XGE_LEN_W  = 14;

    typedef struct packed {
        logic [XGE_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
        logic [XGE_MOD_W-1:0]  mod;
        logic                  err;
    } rx_word_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_READ = 2'd1,
        RX_DONE = 2'd2
    } rx_drain_state_e;

    localparam int FLAG_MAC_ERR  = 0;
    localparam int FLAG_FRAMING  = 1;
    localparam int FLAG_RUNT     = 2;
    localparam int FLAG_OVERSIZE = 3;

    // Add one word's byte count to a running length, saturating at all-ones.
    function automatic logic [XGE_LEN_W-1:0] len_accum(
        input logic [XGE_LEN_W-1:0] len,
        input logic                 eop,
        input logic [XGE_MOD_W-1:0] mod
    );
        logic [3:0]         add;
        logic [XGE_LEN_W:0] sum;
        add = (!eop || (mod == '0)) ? 4'd8 : {1'b0, mod};
        sum = {1'b0, len} + {{(XGE_LEN_W + 1 - 4){1'b0}}, add};
        return sum[XGE_LEN_W] ? {XGE_LEN_W{1'b1}} : sum[XGE_LEN_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/xgemac_skid_buf2.sv
`default_nettype none
// ============================================================================
// xgemac_skid_buf2: 2-entry ordered FIFO of rx words with occupancy output. Rev 1.0
// ============================================================================
module xgemac_skid_buf2
    import xgemac_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  rx_word_t i_push_word,
    input  logic     i_pop,
    output logic [1:0] o_cnt,
    output rx_word_t o_head
);

    rx_word_t   mem0_q, mem0_d;
    rx_word_t   mem1_q, mem1_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       w_do_pop;
    logic       w_do_push;

    assign w_do_pop  = i_pop && (cnt_q != 2'd0);
    // A push into a full buffer is only taken when the head leaves in the same cycle.
    assign w_do_push = i_push && ((cnt_q != 2'd2) || w_do_pop);

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            if (wr_ptr_q) begin
                mem1_d = i_push_word;
            end else begin
                mem0_d = i_push_word;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (w_do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_head = rd_ptr_q ? mem1_q : mem0_q;

endmodule
`default_nettype wire

// File: rtl/xgemac_rx_pkt_drain.sv
`default_nettype none
// ============================================================================
// xgemac_rx_pkt_drain: drains whole MAC rx frames to a valid/ready stream with
// per-frame length/status and running counters. Rev 1.0
// ============================================================================
module xgemac_rx_pkt_drain
    import xgemac_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic                  clk_156m25,
    input  logic                  reset_156m25_n,
    input  logic                  cfg_enable,
    input  logic                  pkt_rx_avail,
    output logic                  pkt_rx_ren,
    input  logic                  pkt_rx_val,
    input  logic [XGE_DATA_W-1:0] pkt_rx_data,
    input  logic                  pkt_rx_sop,
    input  logic                  pkt_rx_eop,
    input  logic [XGE_MOD_W-1:0]  pkt_rx_mod,
    input  logic                  pkt_rx_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XGE_DATA_W-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [XGE_MOD_W-1:0]  out_mod,
    output logic                  out_err,
    output logic                  stat_valid,
    output logic [XGE_LEN_W-1:0]  stat_len,
    output logic [3:0]            stat_flags,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam logic [1:0] ST_IDLE = RX_IDLE;
    localparam logic [1:0] ST_READ = RX_READ;
    localparam logic [1:0] ST_DONE = RX_DONE;

    localparam logic [XGE_LEN_W-1:0] C_MIN_LEN = XGE_LEN_W'(MIN_LEN);
    localparam logic [XGE_LEN_W-1:0] C_MAX_LEN = XGE_LEN_W'(MAX_LEN);

    logic [1:0]           state_q, state_d;
    logic                 ren_q;
    logic [XGE_LEN_W-1:0] len_q, len_d;
    logic                 framing_q, framing_d;
    logic                 mac_err_q, mac_err_d;
    logic                 first_q, first_d;
    logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;

    logic [1:0]           w_cnt;
    rx_word_t             w_head;
    rx_word_t             w_push_word;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_sop_err;
    logic                 w_framing_now;
    logic                 w_mac_now;
    logic [2:0]           w_occ_next;
    logic [XGE_LEN_W-1:0] w_len_next;
    logic [3:0]           w_final_flags;
    logic [3:0]           w_done_flags;

    assign out_valid = (w_cnt != 2'd0);
    assign w_pop     = out_valid && out_ready;
    // A returning word is only genuine if a read was issued the cycle before.
    assign w_accept  = pkt_rx_val && ren_q;

    // Occupancy once this cycle's in-flight word lands and any pop leaves.
    assign w_occ_next = {1'b0, w_cnt} + {2'b0, ren_q} - {2'b0, w_pop};
    assign pkt_rx_ren = (state_q == ST_READ) && !(pkt_rx_val && pkt_rx_eop)
                        && (w_occ_next <= 3'd1);

    assign w_len_next = len_accum(len_q, pkt_rx_eop, pkt_rx_mod);
    assign w_sop_err  = w_accept ? (first_q ? !pkt_rx_sop : pkt_rx_sop)
                                 : (pkt_rx_val && (state_q == ST_READ));
    assign w_framing_now = framing_q || w_sop_err;
    assign w_mac_now     = mac_err_q || (w_accept && pkt_rx_err);

    always_comb begin
        w_final_flags                = '0;
        w_final_flags[FLAG_MAC_ERR]  = w_mac_now;
        w_final_flags[FLAG_FRAMING]  = w_framing_now;
        w_final_flags[FLAG_RUNT]     = (w_len_next < C_MIN_LEN);
        w_final_flags[FLAG_OVERSIZE] = (w_len_next > C_MAX_LEN);
    end

    always_comb begin
        w_done_flags                = '0;
        w_done_flags[FLAG_MAC_ERR]  = mac_err_q;
        w_done_flags[FLAG_FRAMING]  = framing_q;
        w_done_flags[FLAG_RUNT]     = (len_q < C_MIN_LEN);
        w_done_flags[FLAG_OVERSIZE] = (len_q > C_MAX_LEN);
    end

    always_comb begin
        w_push_word.data = pkt_rx_data;
        w_push_word.sop  = pkt_rx_sop;
        w_push_word.eop  = pkt_rx_eop;
        w_push_word.mod  = pkt_rx_mod;
        w_push_word.err  = pkt_rx_eop ? (|w_final_flags) : pkt_rx_err;
    end

    xgemac_skid_buf2 u_skid (
        .clk         (clk_156m25),
        .rst_n       (reset_156m25_n),
        .i_push      (w_accept),
        .i_push_word (w_push_word),
        .i_pop       (w_pop),
        .o_cnt       (w_cnt),
        .o_head      (w_head)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        framing_d = framing_q;
        mac_err_d = mac_err_q;
        first_d   = first_q;
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pkt_rx_avail && cfg_enable) begin
                    state_d   = ST_READ;
                    len_d     = '0;
                    framing_d = 1'b0;
                    mac_err_d = 1'b0;
                    first_d   = 1'b1;
                end
            end
            ST_READ: begin
                framing_d = w_framing_now;
                mac_err_d = w_mac_now;
                if (w_accept) begin
                    len_d   = w_len_next;
                    first_d = 1'b0;
                    if (pkt_rx_eop) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                err_cnt_d = err_cnt_q + CNT_W'(w_done_flags != 4'd0);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q   <= ST_IDLE;
            ren_q     <= 1'b0;
            len_q     <= '0;
            framing_q <= 1'b0;
            mac_err_q <= 1'b0;
            first_q   <= 1'b0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ren_q     <= pkt_rx_ren;
            len_q     <= len_d;
            framing_q <= framing_d;
            mac_err_q <= mac_err_d;
            first_q   <= first_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_data   = w_head.data;
    assign out_sop    = w_head.sop;
    assign out_eop    = w_head.eop;
    assign out_mod    = w_head.mod;
    assign out_err    = w_head.err;
    assign stat_valid = (state_q == ST_DONE);
    assign stat_len   = stat_valid ? len_q : '0;
    assign stat_flags = stat_valid ? w_done_flags : 4'd0;
    assign pkt_cnt    = pkt_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_xgemac_rx_pkt_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_xgemac_rx_pkt_drain: MAC-side frame source, frame-level reference model
// and decoupled scoreboard monitor for the rx packet drain. Rev 1.0
// ============================================================================
module tb_xgemac_rx_pkt_drain;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } word_t;

    typedef struct {
        int         len;
        logic [3:0] flags;
        int         pkt_before;
        int         err_before;
    } stat_t;

    logic        clk_156m25 = 1'b0;
    logic        reset_156m25_n;
    logic        cfg_enable;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic        pkt_rx_val;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_mod;
    logic        out_err;
    logic        stat_valid;
    logic [13:0] stat_len;
    logic [3:0]  stat_flags;
    logic [31:0] pkt_cnt;
    logic [31:0] err_cnt;

    always #5 clk_156m25 = ~clk_156m25;

    xgemac_rx_pkt_drain #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(32)) dut (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .cfg_enable     (cfg_enable),
        .pkt_rx_avail   (pkt_rx_avail),
        .pkt_rx_ren     (pkt_rx_ren),
        .pkt_rx_val     (pkt_rx_val),
        .pkt_rx_data    (pkt_rx_data),
        .pkt_rx_sop     (pkt_rx_sop),
        .pkt_rx_eop     (pkt_rx_eop),
        .pkt_rx_mod     (pkt_rx_mod),
        .pkt_rx_err     (pkt_rx_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_mod        (out_mod),
        .out_err        (out_err),
        .stat_valid     (stat_valid),
        .stat_len       (stat_len),
        .stat_flags     (stat_flags),
        .pkt_cnt        (pkt_cnt),
        .err_cnt        (err_cnt)
    );

    word_t mac_q[$];
    word_t exp_q[$];
    stat_t stat_q[$];

    int checks = 0;
    int errors = 0;
    int mdl_pkt = 0;
    int mdl_err = 0;
    int beat_cnt = 0;
    int ren_run = 0;
    int last_run = 0;
    int ready_mode = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model: a frame's expected beats and status come straight from
    // its word list, computed before the frame is handed to the MAC source.
    task automatic add_frame(input int nw, input logic [2:0] lmod, input bit miss_sop,
                             input bit extra_sop, input bit err_eop, input bit rand_err);
        word_t      w;
        stat_t      s;
        int         len;
        bit         fr;
        bit         me;
        logic [3:0] fl;
        fr = miss_sop || (extra_sop && nw > 1);
        me = 1'b0;
        len = (nw - 1) * 8 + ((lmod == 3'd0) ? 8 : int'(lmod));
        if (len > 16383) len = 16383;
        for (int i = 0; i < nw; i++) begin
            w.data = {$urandom, $urandom};
            w.sop  = (i == 0) ? !miss_sop : (extra_sop && i == nw / 2);
            w.eop  = (i == nw - 1);
            w.mod  = w.eop ? lmod : 3'($urandom_range(0, 7));
            w.err  = (w.eop && err_eop) || (rand_err && $urandom_range(0, 15) == 0);
            me     = me || w.err;
            mac_q.push_back(w);
            if (w.eop) begin
                fl = {len > 1518, len < 64, fr, me};
                w.err = |fl;
            end
            exp_q.push_back(w);
        end
        s.len = len;
        s.flags = {len > 1518, len < 64, fr, me};
        s.pkt_before = mdl_pkt;
        s.err_before = mdl_err;
        stat_q.push_back(s);
        mdl_pkt++;
        if (s.flags != 4'd0) mdl_err++;
    endtask

    // MAC source: answers each ren with the next queued word one cycle later.
    initial begin
        bit ren_s;
        int cyc;
        word_t w;
        bit pat[4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        cyc = 0;
        pkt_rx_val = 1'b0; pkt_rx_data = '0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0;
        pkt_rx_mod = '0; pkt_rx_err = 1'b0; pkt_rx_avail = 1'b0; out_ready = 1'b1;
        forever begin
            @(negedge clk_156m25);
            ren_s = pkt_rx_ren;
            @(posedge clk_156m25);
            #1;
            cyc++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[cyc % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0; pkt_rx_err = 1'b0;
            if (reset_156m25_n && ren_s) begin
                if (mac_q.size() == 0) begin
                    chk(1'b0, "ren_without_word", 64'd1, 64'd0);
                end else begin
                    w = mac_q.pop_front();
                    pkt_rx_val = 1'b1; pkt_rx_data = w.data; pkt_rx_sop = w.sop;
                    pkt_rx_eop = w.eop; pkt_rx_mod = w.mod; pkt_rx_err = w.err;
                end
            end
            pkt_rx_avail = (mac_q.size() != 0);
        end
    end

    // Monitor: port-level occupancy tracking, beat and status scoreboard.
    initial begin
        int occ;
        int ren_prev;
        int pop;
        int push;
        word_t e;
        stat_t s;
        bit ok;
        occ = 0; ren_prev = 0;
        forever begin
            @(negedge clk_156m25);
            if (!reset_156m25_n) begin
                occ = 0; ren_prev = 0; ren_run = 0;
            end else begin
                pop  = int'(out_valid && out_ready);
                push = int'(pkt_rx_val) * ren_prev;
                chk(out_valid == (occ != 0), "out_valid_vs_occupancy", 64'(out_valid), 64'(occ));
                if (pkt_rx_ren) begin
                    chk(occ + ren_prev - pop <= 1, "ren_budget", 64'(occ + ren_prev - pop), 64'd1);
                    chk(!(pkt_rx_val && pkt_rx_eop), "ren_on_eop_return", 64'd1, 64'd0);
                    ren_run++;
                end else if (ren_run != 0) begin
                    last_run = ren_run;
                    ren_run = 0;
                end
                if (pop != 0) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", out_data, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        ok = (out_data == e.data) && (out_sop == e.sop) && (out_eop == e.eop)
                             && (out_mod == e.mod) && (!e.eop || out_err == e.err);
                        checks++;
                        if (!ok) begin
                            errors++;
                            $display("FAIL beat%0d: actual data=%h sop=%b eop=%b mod=%0d err=%b required data=%h sop=%b eop=%b mod=%0d err=%b",
                                     beat_cnt, out_data, out_sop, out_eop, out_mod, out_err,
                                     e.data, e.sop, e.eop, e.mod, e.err);
                        end
                    end
                    beat_cnt++;
                end
                if (stat_valid) begin
                    if (stat_q.size() == 0) begin
                        chk(1'b0, "unexpected_stat", 64'(stat_len), 64'd0);
                    end else begin
                        s = stat_q.pop_front();
                        chk(int'(stat_len) == s.len, "stat_len", 64'(stat_len), 64'(s.len));
                        chk(stat_flags == s.flags, "stat_flags", 64'(stat_flags), 64'(s.flags));
                        chk(pkt_cnt == 32'(s.pkt_before), "pkt_cnt_before", 64'(pkt_cnt), 64'(s.pkt_before));
                        chk(err_cnt == 32'(s.err_before), "err_cnt_before", 64'(err_cnt), 64'(s.err_before));
                    end
                end
                occ = occ + push - pop;
                chk(occ >= 0 && occ <= 2, "occupancy_range", 64'(occ), 64'd2);
                ren_prev = int'(pkt_rx_ren);
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((mac_q.size() != 0 || exp_q.size() != 0 || stat_q.size() != 0) && n < budget) begin
            @(negedge clk_156m25);
            n++;
        end
        chk(n < budget, "drain_timeout", 64'(exp_q.size()), 64'd0);
        mac_q.delete(); exp_q.delete(); stat_q.delete();
        repeat (2) @(negedge clk_156m25);
        chk(pkt_cnt == 32'(mdl_pkt), "pkt_cnt", 64'(pkt_cnt), 64'(mdl_pkt));
        chk(err_cnt == 32'(mdl_err), "err_cnt", 64'(err_cnt), 64'(mdl_err));
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beat_cnt < target && n < budget) begin
            @(negedge clk_156m25);
            n++;
        end
        chk(beat_cnt >= target, "beat_wait_timeout", 64'(beat_cnt), 64'(target));
    endtask

    task automatic check_all_zero(input string tag);
        chk({pkt_rx_ren, out_valid, out_sop, out_eop, out_mod, out_err, stat_valid} == '0,
            {tag, "_ctrl"}, 64'({pkt_rx_ren, out_valid, out_sop, out_eop, out_mod, out_err, stat_valid}), 64'd0);
        chk(out_data == '0, {tag, "_data"}, out_data, 64'd0);
        chk({stat_len, stat_flags} == '0, {tag, "_stat"}, 64'({stat_len, stat_flags}), 64'd0);
        chk({pkt_cnt, err_cnt} == '0, {tag, "_counters"}, {pkt_cnt, err_cnt}, 64'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_156m25_n = 1'b0;
        cfg_enable = 1'b1;
        repeat (3) @(posedge clk_156m25);
        #2;
        check_all_zero("reset");
        reset_156m25_n = 1'b1;

        // 64-byte frame at full rate
        add_frame(8, 3'd0, 0, 0, 0, 0);
        drain(2000);
        chk(last_run == 8, "ren_run_64B", 64'(last_run), 64'd8);

        // length limits and runts
        add_frame(190, 3'd6, 0, 0, 0, 0);
        add_frame(190, 3'd7, 0, 0, 0, 0);
        drain(5000);
        add_frame(5, 3'd0, 0, 0, 0, 0);
        add_frame(8, 3'd5, 0, 0, 0, 0);
        add_frame(8, 3'd7, 0, 0, 0, 0);
        add_frame(9, 3'd1, 0, 0, 0, 0);
        add_frame(1, 3'd3, 0, 0, 0, 0);
        drain(2000);

        // backpressure pattern 1,0,0,1
        ready_mode = 1;
        add_frame(16, 3'd0, 0, 0, 0, 0);
        drain(2000);
        ready_mode = 0;

        // MAC error and framing errors
        add_frame(8, 3'd0, 0, 0, 1, 0);
        add_frame(8, 3'd0, 1, 0, 0, 0);
        add_frame(10, 3'd2, 0, 1, 0, 0);
        drain(2000);

        // length saturation
        add_frame(2050, 3'd0, 0, 0, 0, 0);
        drain(6000);

        // cfg_enable dropped mid-frame blocks only the next start
        base = beat_cnt;
        add_frame(20, 3'd0, 0, 0, 0, 0);
        add_frame(6, 3'd4, 0, 0, 0, 0);
        wait_beats(base + 1, 200);
        cfg_enable = 1'b0;
        repeat (60) @(negedge clk_156m25);
        chk(exp_q.size() == 6, "cfg_disable_blocks_start", 64'(exp_q.size()), 64'd6);
        chk(stat_q.size() == 1, "cfg_disable_frame_done", 64'(stat_q.size()), 64'd1);
        cfg_enable = 1'b1;
        drain(2000);

        // randomized frames under random backpressure
        ready_mode = 2;
        for (int f = 0; f < 30; f++) begin
            add_frame($urandom_range(1, 40), 3'($urandom_range(0, 7)),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0, 1'b1);
        end
        drain(10000);
        ready_mode = 0;

        // asynchronous reset in the middle of a frame
        base = beat_cnt;
        add_frame(8, 3'd0, 0, 0, 0, 0);
        wait_beats(base + 3, 200);
        @(posedge clk_156m25);
        #2;
        reset_156m25_n = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        mac_q.delete(); exp_q.delete(); stat_q.delete();
        mdl_pkt = 0; mdl_err = 0;
        repeat (3) @(posedge clk_156m25);
        #2;
        reset_156m25_n = 1'b1;
        add_frame(8, 3'd0, 0, 0, 0, 0);
        drain(2000);

        repeat (5) @(negedge clk_156m25);
        chk(exp_q.size() == 0, "final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
